// File: rtl/vga_timing_pkg.sv
// 640x480@60 timing constants shared by vga_driver and vga_sync_receiver,
// plus the receiver lock-state encoding.
package vga_timing_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int H_TOTAL   = 800;
    localparam int V_VISIBLE = 480;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam int V_TOTAL   = 525;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } rx_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Sync input register with inactive->active leading-edge detect.
// The registered level is compared against one more delayed copy so the
// edge pulse lines up with the stage-1 sample of the pixel data.
module sync_edge_det #(
    parameter bit SYNC_POL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic sync_in,
    output logic lead
);

    logic sync_q;
    logic sync_qq;

    // Sample the pin and keep the previous sample; reset to the idle level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q  <= ~SYNC_POL;
            sync_qq <= ~SYNC_POL;
        end else begin
            sync_q  <= sync_in;
            sync_qq <= sync_q;
        end
    end

    assign lead = (sync_q == SYNC_POL) && (sync_qq != SYNC_POL);

endmodule

// File: rtl/vga_sync_receiver.sv
// VGA receiver: recovers pixel coordinates from hsync/vsync, checks line and
// frame lengths, and declares lock after LOCK_FRAMES clean frames.
// Stage 1 is the input registers; counters and outputs update in stage 2,
// so pix_*/frame_start/err_* trail the pins by two clocks.
module vga_sync_receiver
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE   = vga_timing_pkg::H_VISIBLE,
    parameter int H_SYNC      = vga_timing_pkg::H_SYNC,
    parameter int H_BP        = vga_timing_pkg::H_BP,
    parameter int H_TOTAL     = vga_timing_pkg::H_TOTAL,
    parameter int V_VISIBLE   = vga_timing_pkg::V_VISIBLE,
    parameter int V_SYNC      = vga_timing_pkg::V_SYNC,
    parameter int V_BP        = vga_timing_pkg::V_BP,
    parameter int V_TOTAL     = vga_timing_pkg::V_TOTAL,
    parameter bit SYNC_POL    = 1'b0,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic [1:0] red_in,
    input  logic [1:0] green_in,
    input  logic [1:0] blue_in,
    output logic       pix_valid,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic [5:0] pix_rgb,
    output logic       frame_start,
    output logic       locked,
    output logic       err_hlen,
    output logic       err_vlen
);

    localparam logic [10:0] H_TOT = 11'(H_TOTAL);
    localparam logic [10:0] H_MAX = 11'(2 * H_TOTAL - 1);
    localparam logic [10:0] HV0   = 11'(H_SYNC + H_BP);
    localparam logic [10:0] HV1   = 11'(H_SYNC + H_BP + H_VISIBLE - 1);
    localparam logic [10:0] V_TOT = 11'(V_TOTAL);
    localparam logic [9:0]  VV0   = 10'(V_SYNC + V_BP);
    localparam logic [9:0]  VV1   = 10'(V_SYNC + V_BP + V_VISIBLE - 1);
    localparam logic [9:0]  V_MAX = 10'd1023;

    logic        hedge, vedge;
    logic [5:0]  rgb_q;
    logic [10:0] hcnt, hcnt_nx;
    logic [9:0]  vcnt, vcnt_nx;
    logic        hchk, vchk;
    logic        herr, verr, err_any;
    logic        vis, show;
    logic [3:0]  good;
    rx_state_t   state;

    sync_edge_det #(.SYNC_POL(SYNC_POL)) u_hs (
        .clk     (clk),
        .rst     (rst),
        .sync_in (hsync_in),
        .lead    (hedge)
    );

    sync_edge_det #(.SYNC_POL(SYNC_POL)) u_vs (
        .clk     (clk),
        .rst     (rst),
        .sync_in (vsync_in),
        .lead    (vedge)
    );

    // Stage-1 colour sample, aligned with the registered syncs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rgb_q <= '0;
        else      rgb_q <= {red_in, green_in, blue_in};
    end

    // Next counter values for the stage-1 sample and the length checks.
    always_comb begin
        hcnt_nx = hcnt;
        herr    = 1'b0;
        if (hedge) begin
            hcnt_nx = '0;
            herr    = hchk && (hcnt + 11'd1 != H_TOT);
        end else if (hcnt != H_MAX) begin
            hcnt_nx = hcnt + 11'd1;
            herr    = (hcnt + 11'd1 == H_MAX);
        end

        vcnt_nx = vcnt;
        verr    = 1'b0;
        if (vedge) begin
            vcnt_nx = '0;
            verr    = vchk && ({1'b0, vcnt} + 11'd1 != V_TOT);
        end else if (hedge && vcnt != V_MAX) begin
            vcnt_nx = vcnt + 10'd1;
            verr    = (vcnt + 10'd1 == V_MAX);
        end

        err_any = herr || verr;
        vis     = (hcnt_nx >= HV0) && (hcnt_nx <= HV1) &&
                  (vcnt_nx >= VV0) && (vcnt_nx <= VV1);
        show    = vis && (state == LOCKED);
    end

    // Position counters; length checks are re-armed by the first edge after an error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcnt <= '0;
            vcnt <= '0;
            hchk <= 1'b0;
            vchk <= 1'b0;
        end else begin
            hcnt <= hcnt_nx;
            vcnt <= vcnt_nx;
            hchk <= err_any ? 1'b0 : (hedge ? 1'b1 : hchk);
            vchk <= err_any ? 1'b0 : (vedge ? 1'b1 : vchk);
        end
    end

    // Lock FSM: errors always win over a same-cycle vsync edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= SEARCH;
            good   <= '0;
            locked <= 1'b0;
        end else begin
            locked <= (state == LOCKED);
            if (err_any) begin
                state <= SEARCH;
                good  <= '0;
            end else if (vedge) begin
                case (state)
                    SEARCH: begin
                        state <= TRACK;
                        good  <= '0;
                    end
                    TRACK: begin
                        good <= good + 4'd1;
                        if (good + 4'd1 == 4'(LOCK_FRAMES)) state <= LOCKED;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Stage-2 output registers; pixel fields read zero outside the locked visible area.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_rgb     <= '0;
            frame_start <= 1'b0;
            err_hlen    <= 1'b0;
            err_vlen    <= 1'b0;
        end else begin
            pix_valid   <= show;
            pix_x       <= show ? 10'(hcnt_nx - HV0) : '0;
            pix_y       <= show ? (vcnt_nx - VV0) : '0;
            pix_rgb     <= show ? rgb_q : '0;
            frame_start <= vedge;
            err_hlen    <= herr;
            err_vlen    <= verr;
        end
    end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver using a scaled-down 16x10 timing.
module tb_vga_sync_receiver;

    localparam int HV = 8, HS = 2, HB = 2, HT = 16;
    localparam int VV = 4, VS = 1, VB = 2, VT = 10;
    localparam int FR = HT * VT;

    logic       clk = 1'b0, rst = 1'b0;
    logic       hsync_in = 1'b1, vsync_in = 1'b1;
    logic [1:0] red_in = '0, green_in = '0, blue_in = '0;
    logic       pix_valid, frame_start, locked, err_hlen, err_vlen;
    logic [9:0] pix_x, pix_y;
    logic [5:0] pix_rgb;

    int errors = 0, checks = 0;
    int hc = 0, vc = 0, ht = HT, vt = VT;
    bit hs_kill = 1'b0, vs_kill = 1'b0;
    int fs_cnt = 0, eh_cnt = 0, ev_cnt = 0, pv_cnt = 0;

    always #20 clk = ~clk;

    vga_sync_receiver #(
        .H_VISIBLE(HV), .H_SYNC(HS), .H_BP(HB), .H_TOTAL(HT),
        .V_VISIBLE(VV), .V_SYNC(VS), .V_BP(VB), .V_TOTAL(VT),
        .SYNC_POL(1'b0), .LOCK_FRAMES(2)
    ) dut (
        .clk(clk), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
        .frame_start(frame_start), .locked(locked),
        .err_hlen(err_hlen), .err_vlen(err_vlen)
    );

    always @(negedge clk) begin
        if (frame_start) fs_cnt <= fs_cnt + 1;
        if (err_hlen)    eh_cnt <= eh_cnt + 1;
        if (err_vlen)    ev_cnt <= ev_cnt + 1;
        if (pix_valid)   pv_cnt <= pv_cnt + 1;
    end

    function automatic logic [5:0] pat(input int h, input int v);
        if (h == HS + HB && v == VS + VB) return 6'h2D;
        return 6'(h * 5 + v * 3 + 1);
    endfunction

    // Drive one pixel of the source timing, then advance one clock.
    task automatic step();
        hsync_in = (hs_kill || hc >= HS);
        vsync_in = (vs_kill || vc >= VS);
        if (hc >= HS + HB && hc < HS + HB + HV && vc >= VS + VB && vc < VS + VB + VV)
            {red_in, green_in, blue_in} = pat(hc, vc);
        else
            {red_in, green_in, blue_in} = 6'd0;
        @(posedge clk); #1;
        hc++;
        if (hc >= ht) begin
            hc = 0; ht = HT; vc++;
            if (vc >= vt) begin vc = 0; vt = VT; end
        end
    endtask

    task automatic run_to(input int h, input int v);
        int n = 0;
        while (!(hc == h && vc == v) && n < 4 * FR) begin step(); n++; end
        if (!(hc == h && vc == v)) begin
            checks++; errors++;
            $display("FAIL run_to: driver at %0d,%0d required %0d,%0d", hc, vc, h, v);
        end
    endtask

    task automatic test_reset();
        logic [29:0] o;
        repeat (3) @(posedge clk);
        #1;
        o = {pix_valid, pix_x, pix_y, pix_rgb, frame_start, err_hlen, err_vlen};
        checks++; if (o !== 30'd0) begin errors++; $display("FAIL reset_outs: got %h required 0", o); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b required 0", locked); end
        rst = 1'b1;
    endtask

    task automatic test_lock();
        repeat (2 * FR + 2) step();
        checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL lock_fs3: got %b required 1", frame_start); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock_early: got %b required 0", locked); end
        step();
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_rise: got %b required 1", locked); end
        repeat (7 * FR) step();
        checks++; if (fs_cnt !== 10) begin errors++; $display("FAIL lock_fs_count: got %0d required 10", fs_cnt); end
        checks++; if (eh_cnt + ev_cnt !== 0) begin errors++; $display("FAIL lock_no_err: got %0d/%0d required 0/0", eh_cnt, ev_cnt); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_hold: got %b required 1", locked); end
    endtask

    task automatic test_pixel();
        run_to(HS + HB, VS + VB); step();
        checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL pix_before: valid=%b required 0", pix_valid); end
        step();
        checks++; if ({pix_valid, pix_x, pix_y} !== {1'b1, 10'd0, 10'd0})
            begin errors++; $display("FAIL pix_first: v=%b x=%0d y=%0d required 1,0,0", pix_valid, pix_x, pix_y); end
        checks++; if (pix_rgb !== 6'h2D) begin errors++; $display("FAIL pix_rgb: got %h required 2d", pix_rgb); end
        run_to(HS + HB + HV - 1, VS + VB); step(); step();
        checks++; if ({pix_valid, pix_x, pix_rgb} !== {1'b1, 10'(HV - 1), pat(HS + HB + HV - 1, VS + VB)})
            begin errors++; $display("FAIL pix_last: v=%b x=%0d rgb=%h required 1,%0d,%h", pix_valid, pix_x, pix_rgb, HV - 1, pat(HS + HB + HV - 1, VS + VB)); end
        step();
        checks++; if ({pix_valid, pix_x, pix_rgb} !== 17'd0)
            begin errors++; $display("FAIL pix_after: v=%b x=%0d rgb=%h required 0", pix_valid, pix_x, pix_rgb); end
        run_to(HS + HB, VS + VB + VV - 1); step(); step();
        checks++; if ({pix_valid, pix_y} !== {1'b1, 10'(VV - 1)})
            begin errors++; $display("FAIL pix_lastrow: v=%b y=%0d required 1,%0d", pix_valid, pix_y, VV - 1); end
        run_to(HS + HB, VS + VB + VV); step(); step();
        checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL pix_belowrow: v=%b required 0", pix_valid); end
    endtask

    task automatic test_relock();
        run_to(0, 0);
        repeat (2 * FR + 2) step();
        checks++; if ({locked, frame_start} !== 2'b01)
            begin errors++; $display("FAIL relock_pre: locked=%b fs=%b required 0,1", locked, frame_start); end
        step();
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL relock: locked=%b required 1", locked); end
    endtask

    task automatic test_short_line();
        run_to(0, 5); ht = HT - 1;
        run_to(0, 6); step(); step();
        checks++; if ({err_hlen, locked} !== 2'b11)
            begin errors++; $display("FAIL short_line_err: err=%b locked=%b required 1,1", err_hlen, locked); end
        step();
        checks++; if ({err_hlen, locked} !== 2'b00)
            begin errors++; $display("FAIL short_line_drop: err=%b locked=%b required 0,0", err_hlen, locked); end
        test_relock();
    endtask

    task automatic test_hsync_timeout();
        int e0, p0;
        run_to(0, 1); step();
        hs_kill = 1'b1; e0 = eh_cnt; p0 = pv_cnt;
        repeat (2 * HT - 1) step();
        checks++; if (err_hlen !== 1'b0) begin errors++; $display("FAIL hto_early: err=%b required 0", err_hlen); end
        step();
        checks++; if (err_hlen !== 1'b1) begin errors++; $display("FAIL hto_fire: err=%b required 1", err_hlen); end
        repeat (40) step();
        checks++; if (eh_cnt - e0 !== 1) begin errors++; $display("FAIL hto_once: count=%0d required 1", eh_cnt - e0); end
        checks++; if (pv_cnt !== p0) begin errors++; $display("FAIL hto_valid: count=%0d required %0d", pv_cnt, p0); end
        run_to(0, 6); hs_kill = 1'b0;
        test_relock();
    endtask

    task automatic test_short_frame();
        run_to(0, 1); vt = VT - 1;
        run_to(0, 0); step(); step();
        checks++; if ({err_vlen, frame_start, locked} !== 3'b111)
            begin errors++; $display("FAIL short_frame: err=%b fs=%b locked=%b required 1,1,1", err_vlen, frame_start, locked); end
        step();
        checks++; if ({err_vlen, locked} !== 2'b00)
            begin errors++; $display("FAIL short_frame_drop: err=%b locked=%b required 0,0", err_vlen, locked); end
    endtask

    task automatic test_vsat();
        int e0, h0;
        run_to(0, 0); step();
        vs_kill = 1'b1; e0 = ev_cnt; h0 = eh_cnt;
        repeat (1022 * HT) step();
        checks++; if (ev_cnt !== e0) begin errors++; $display("FAIL vsat_early: count=%0d required %0d", ev_cnt, e0); end
        repeat (2 * HT) step();
        checks++; if (ev_cnt !== e0 + 1) begin errors++; $display("FAIL vsat_fire: count=%0d required %0d", ev_cnt, e0 + 1); end
        repeat (4 * HT) step();
        checks++; if ({ev_cnt - e0, eh_cnt - h0} !== {32'd1, 32'd0})
            begin errors++; $display("FAIL vsat_once: v=%0d h=%0d required 1,0", ev_cnt - e0, eh_cnt - h0); end
        run_to(0, 5); vs_kill = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [29:0] o;
        test_relock();
        run_to(HS + HB + 2, VS + VB + 1); step(); step();
        checks++; if ({pix_valid, pix_x, pix_y, pix_rgb} !== {1'b1, 10'd2, 10'd1, pat(HS + HB + 2, VS + VB + 1)})
            begin errors++; $display("FAIL mid_pix: v=%b x=%0d y=%0d rgb=%h required 1,2,1,%h", pix_valid, pix_x, pix_y, pix_rgb, pat(HS + HB + 2, VS + VB + 1)); end
        rst = 1'b0; #1;
        o = {pix_valid, pix_x, pix_y, pix_rgb, frame_start, err_hlen, err_vlen};
        checks++; if ({o, locked} !== 31'd0)
            begin errors++; $display("FAIL mid_reset: outs=%h locked=%b required 0", o, locked); end
        repeat (3) step();
        rst = 1'b1;
        test_relock();
    endtask

    initial begin
        test_reset();
        test_lock();
        test_pixel();
        test_short_line();
        test_hsync_timeout();
        test_short_frame();
        test_vsat();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
